bch_check_scoreboard: RTL and testbench

Parametrised, synthesizable self-check scoreboard for BCH encode/decode test harnesses.
- Queues the injected error pattern of every accepted codeword.
- Checks decoder outputs against the queue: errors-present flag, error count, and the serial error-location stream.
- Successor to the fixed 16-deep check stacks: depth, beat width and error-count width are generic; adds occupancy/underflow detection, framing checks and pass/fail counters.
- Sits beside encoder, syndrome, key-equation and Chien blocks in sims and on-FPGA BIST.

---
 rtl/bch_check_scoreboard.sv | 232 +++++++++++++++++++++++
 tb/tb_bch_check_scoreboard.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_check_scoreboard.sv
// Scoreboard checking BCH decoder outputs (present flag, error count, error-location stream) against queued injected errors.
// Latency: failures flagged one cycle after the offending strobe/compare; BCH_SB_DATA_CHECK_EN adds a received-data queue and check.
// Backpressure: ready drops while any queue holds DEPTH entries; pushes seen while not ready are dropped and counted as failures.
module bch_check_scoreboard #(
    parameter int DATA_BITS = 32,
    parameter int BITS      = 1,
    parameter int ERR_SZ    = 4,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    input  logic [DATA_BITS-1:0] wr_error,
`ifdef BCH_SB_DATA_CHECK_EN
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rx_valid,
    input  logic [BITS-1:0]      rx_in,
    output logic                 data_ok,
`endif
    output logic                 ready,
    input  logic                 present_valid,
    input  logic                 present_in,
    input  logic                 count_valid,
    input  logic [ERR_SZ-1:0]    count_in,
    input  logic                 err_first,
    input  logic                 err_valid,
    input  logic                 err_last,
    input  logic [BITS-1:0]      err_in,
    output logic                 mismatch,
    output logic                 wrong,
    output logic [CNT_W-1:0]     words_checked,
    output logic [CNT_W-1:0]     fail_count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int OW     = AW + 1;
    localparam int NBEATS = DATA_BITS / BITS;
    localparam int BW     = $clog2(NBEATS + 1);
`ifdef BCH_SB_DATA_CHECK_EN
    localparam int NF     = 9;
`else
    localparam int NF     = 8;
`endif
    localparam int NFW    = $clog2(NF + 1);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    if (DATA_BITS % BITS != 0) begin : g_bad_bits
        $error("DATA_BITS must be a multiple of BITS");
    end
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMPARE} state_t;

    function automatic logic [ERR_SZ-1:0] popcnt(input logic [DATA_BITS-1:0] v);
        logic [ERR_SZ-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BITS; i++) c = c + ERR_SZ'(v[i]);
        return c;
    endfunction

    logic [DATA_BITS-1:0] pat_mem [DEPTH];
    logic [ERR_SZ-1:0]    pc_mem  [DEPTH];
    logic                 pr_mem  [DEPTH];
    logic [AW-1:0]        wr_ptr, pat_rd, pc_rd, pr_rd;
    logic [OW-1:0]        pat_occ, pc_occ, pr_occ;

    state_t               state;
    logic [BW-1:0]        beat_cnt;
    logic [DATA_BITS-1:0] asm_err;

    logic push, pat_pop, pc_pop, pr_pop, in_compare;
    logic f_ovf, f_pr_unf, f_pr_mis, f_pc_unf, f_pc_mis, f_pat_unf, f_vec, f_frame;
    logic [NF-1:0]    fails;
    logic [NFW-1:0]   nfail;
    logic [CNT_W:0]   fsum;

`ifdef BCH_SB_DATA_CHECK_EN
    logic [DATA_BITS-1:0] dat_mem [DEPTH];
    logic [AW-1:0]        dat_rd;
    logic [OW-1:0]        dat_occ;
    logic [DATA_BITS-1:0] asm_rx;
    logic                 dat_pop, f_data;

    assign ready   = (pat_occ != FULL) && (pc_occ != FULL) && (pr_occ != FULL) && (dat_occ != FULL);
    assign dat_pop = in_compare && (dat_occ != '0);
    assign f_data  = pat_pop && dat_pop && ((asm_rx ^ asm_err) !== dat_mem[dat_rd]);
    assign fails   = {f_data, f_ovf, f_pr_unf, f_pr_mis, f_pc_unf, f_pc_mis, f_pat_unf, f_vec, f_frame};
`else
    assign ready   = (pat_occ != FULL) && (pc_occ != FULL) && (pr_occ != FULL);
    assign fails   = {f_ovf, f_pr_unf, f_pr_mis, f_pc_unf, f_pc_mis, f_pat_unf, f_vec, f_frame};
`endif

    assign push       = wr_valid && ready;
    assign f_ovf      = wr_valid && !ready;
    assign pr_pop     = present_valid && (pr_occ != '0);
    assign f_pr_unf   = present_valid && (pr_occ == '0);
    assign f_pr_mis   = pr_pop && (present_in !== pr_mem[pr_rd]);
    assign pc_pop     = count_valid && (pc_occ != '0);
    assign f_pc_unf   = count_valid && (pc_occ == '0);
    assign f_pc_mis   = pc_pop && (count_in !== pc_mem[pc_rd]);
    assign in_compare = (state == S_COMPARE);
    assign pat_pop    = in_compare && (pat_occ != '0);
    assign f_pat_unf  = in_compare && (pat_occ == '0);
    assign f_vec      = pat_pop && (asm_err !== pat_mem[pat_rd]);

    // Bad framing: early/late err_last, err_first inside a frame, or beats past the frame end.
    always_comb begin
        f_frame = 1'b0;
        if (err_valid) begin
            if (state == S_IDLE) begin
                f_frame = err_first && err_last && (NBEATS != 1);
            end else if (state == S_COLLECT) begin
                if (err_first || int'(beat_cnt) >= NBEATS)
                    f_frame = 1'b1;
                else if (err_last && (int'(beat_cnt) + 1 != NBEATS))
                    f_frame = 1'b1;
            end
        end
    end

    always_comb begin
        nfail = '0;
        for (int i = 0; i < NF; i++) nfail = nfail + NFW'(fails[i]);
    end
    assign fsum = {1'b0, fail_count} + (CNT_W + 1)'(nfail);

    always_ff @(posedge clk) begin
        if (push) begin
            pat_mem[wr_ptr] <= wr_error;
            pc_mem[wr_ptr]  <= popcnt(wr_error);
            pr_mem[wr_ptr]  <= |wr_error;
`ifdef BCH_SB_DATA_CHECK_EN
            dat_mem[wr_ptr] <= wr_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            pat_rd  <= '0;
            pc_rd   <= '0;
            pr_rd   <= '0;
            pat_occ <= '0;
            pc_occ  <= '0;
            pr_occ  <= '0;
`ifdef BCH_SB_DATA_CHECK_EN
            dat_rd  <= '0;
            dat_occ <= '0;
`endif
        end else begin
            if (push)    wr_ptr <= wr_ptr + AW'(1);
            if (pat_pop) pat_rd <= pat_rd + AW'(1);
            if (pc_pop)  pc_rd  <= pc_rd + AW'(1);
            if (pr_pop)  pr_rd  <= pr_rd + AW'(1);
            pat_occ <= pat_occ + OW'(push) - OW'(pat_pop);
            pc_occ  <= pc_occ + OW'(push) - OW'(pc_pop);
            pr_occ  <= pr_occ + OW'(push) - OW'(pr_pop);
`ifdef BCH_SB_DATA_CHECK_EN
            if (dat_pop) dat_rd <= dat_rd + AW'(1);
            dat_occ <= dat_occ + OW'(push) - OW'(dat_pop);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            asm_err  <= '0;
`ifdef BCH_SB_DATA_CHECK_EN
            asm_rx   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_COLLECT: begin
                    if (err_valid && (err_first || state == S_IDLE)) begin
                        if (err_first) begin
                            // Start (or restart) a frame with this beat.
                            asm_err  <= DATA_BITS'(err_in);
`ifdef BCH_SB_DATA_CHECK_EN
                            asm_rx   <= rx_valid ? DATA_BITS'(rx_in) : '0;
`endif
                            beat_cnt <= BW'(1);
                            if (err_last) state <= (NBEATS == 1) ? S_COMPARE : S_IDLE;
                            else          state <= S_COLLECT;
                        end
                    end else if (err_valid) begin
                        if (int'(beat_cnt) >= NBEATS) begin
                            state <= S_IDLE;
                        end else begin
                            asm_err[beat_cnt*BITS +: BITS] <= err_in;
`ifdef BCH_SB_DATA_CHECK_EN
                            if (rx_valid) asm_rx[beat_cnt*BITS +: BITS] <= rx_in;
`endif
                            beat_cnt <= beat_cnt + BW'(1);
                            if (err_last)
                                state <= (int'(beat_cnt) + 1 == NBEATS) ? S_COMPARE : S_IDLE;
                        end
                    end
                end
                S_COMPARE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch      <= 1'b0;
            wrong         <= 1'b0;
            words_checked <= '0;
            fail_count    <= '0;
`ifdef BCH_SB_DATA_CHECK_EN
            data_ok       <= 1'b1;
`endif
        end else begin
            mismatch   <= |fails;
            wrong      <= wrong | (|fails);
            fail_count <= fsum[CNT_W] ? '1 : fsum[CNT_W-1:0];
            if (in_compare && words_checked != '1)
                words_checked <= words_checked + CNT_W'(1);
`ifdef BCH_SB_DATA_CHECK_EN
            if (f_data) data_ok <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_bch_check_scoreboard.sv
// Directed bench for bch_check_scoreboard: 32-bit patterns, 4-bit beats, 4-deep queues.
module tb_bch_check_scoreboard;

    localparam int DB = 32;
    localparam int BT = 4;
    localparam int ES = 4;
    localparam int DP = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic [DB-1:0] wr_error;
    logic          ready;
    logic          present_valid, present_in;
    logic          count_valid;
    logic [ES-1:0] count_in;
    logic          err_first, err_valid, err_last;
    logic [BT-1:0] err_in;
    logic          mismatch, wrong;
    logic [CW-1:0] words_checked, fail_count;
`ifdef BCH_SB_DATA_CHECK_EN
    logic [DB-1:0] wr_data;
    logic          rx_valid;
    logic [BT-1:0] rx_in;
    logic          data_ok;
`endif

    int checks = 0;
    int passed = 0;
    int mm_total = 0;

    always #5 clk = ~clk;

    bch_check_scoreboard #(
        .DATA_BITS(DB), .BITS(BT), .ERR_SZ(ES), .DEPTH(DP), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_error(wr_error),
`ifdef BCH_SB_DATA_CHECK_EN
        .wr_data(wr_data), .rx_valid(rx_valid), .rx_in(rx_in), .data_ok(data_ok),
`endif
        .ready(ready),
        .present_valid(present_valid), .present_in(present_in),
        .count_valid(count_valid), .count_in(count_in),
        .err_first(err_first), .err_valid(err_valid), .err_last(err_last), .err_in(err_in),
        .mismatch(mismatch), .wrong(wrong),
        .words_checked(words_checked), .fail_count(fail_count)
    );

    always @(negedge clk) if (mismatch === 1'b1) mm_total++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_valid = 1'b0; wr_error = '0;
        present_valid = 1'b0; present_in = 1'b0;
        count_valid = 1'b0; count_in = '0;
        err_first = 1'b0; err_valid = 1'b0; err_last = 1'b0; err_in = '0;
`ifdef BCH_SB_DATA_CHECK_EN
        wr_data = '0; rx_valid = 1'b0; rx_in = '0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [DB-1:0] p);
        wr_valid = 1'b1; wr_error = p;
`ifdef BCH_SB_DATA_CHECK_EN
        wr_data = p;
`endif
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic send_present(input logic v);
        present_valid = 1'b1; present_in = v;
        @(negedge clk);
        present_valid = 1'b0;
    endtask

    task automatic send_count(input logic [ES-1:0] c);
        count_valid = 1'b1; count_in = c;
        @(negedge clk);
        count_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [DB-1:0] p, input int nb, input bit with_last);
        for (int i = 0; i < nb; i++) begin
            err_valid = 1'b1;
            err_first = (i == 0);
            err_last  = with_last && (i == nb - 1);
            err_in    = p[i*BT +: BT];
            @(negedge clk);
        end
        err_valid = 1'b0; err_first = 1'b0; err_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
        checks++; if (wrong !== 1'b0) $display("FAIL reset_wrong got %b want 0", wrong); else passed++;
        checks++; if (mismatch !== 1'b0) $display("FAIL reset_mismatch got %b want 0", mismatch); else passed++;
        checks++; if (words_checked !== 16'd0) $display("FAIL reset_words got %0d want 0", words_checked); else passed++;
        checks++; if (fail_count !== 16'd0) $display("FAIL reset_fails got %0d want 0", fail_count); else passed++;
    endtask

    task automatic test_clean();
        int base;
        do_reset();
        base = mm_total;
        push(32'h0);
        send_present(1'b0);
        send_count(4'd0);
        send_stream(32'h0, 8, 1'b1);
        tick();
        checks++; if (words_checked !== 16'd1) $display("FAIL clean_words got %0d want 1", words_checked); else passed++;
        checks++; if (wrong !== 1'b0) $display("FAIL clean_wrong got %b want 0", wrong); else passed++;
        checks++; if (mm_total - base !== 0) $display("FAIL clean_pulses got %0d want 0", mm_total - base); else passed++;
        checks++; if (fail_count !== 16'd0) $display("FAIL clean_fails got %0d want 0", fail_count); else passed++;
    endtask

    task automatic test_correct_errors();
        int base;
        do_reset();
        base = mm_total;
        push(32'h8000_0011);
        send_present(1'b1);
        send_count(4'd3);
        send_stream(32'h8000_0011, 8, 1'b1);
        tick();
        checks++; if (words_checked !== 16'd1) $display("FAIL correct_words got %0d want 1", words_checked); else passed++;
        checks++; if (fail_count !== 16'd0) $display("FAIL correct_fails got %0d want 0", fail_count); else passed++;
        checks++; if (mm_total - base !== 0) $display("FAIL correct_pulses got %0d want 0", mm_total - base); else passed++;
    endtask

    task automatic test_wrong_count();
        do_reset();
        push(32'h3);
        send_present(1'b1);
        send_count(4'd1);
        checks++; if (mismatch !== 1'b1) $display("FAIL wcount_pulse got %b want 1", mismatch); else passed++;
        checks++; if (wrong !== 1'b1) $display("FAIL wcount_wrong got %b want 1", wrong); else passed++;
        checks++; if (fail_count !== 16'd1) $display("FAIL wcount_fails got %0d want 1", fail_count); else passed++;
        tick();
        checks++; if (mismatch !== 1'b0) $display("FAIL wcount_pulse_end got %b want 0", mismatch); else passed++;
        checks++; if (wrong !== 1'b1) $display("FAIL wcount_sticky got %b want 1", wrong); else passed++;
        send_stream(32'h3, 8, 1'b1);
        tick();
        checks++; if (words_checked !== 16'd1) $display("FAIL wcount_words got %0d want 1", words_checked); else passed++;
        checks++; if (fail_count !== 16'd1) $display("FAIL wcount_fails_end got %0d want 1", fail_count); else passed++;
    endtask

    task automatic test_overflow();
        logic [DB-1:0] pats [4];
        logic [ES-1:0] pcs [4];
        pats = '{32'h0000_0001, 32'h0000_0030, 32'h0000_0000, 32'hF000_0000};
        pcs  = '{4'd1, 4'd2, 4'd0, 4'd4};
        do_reset();
        for (int i = 0; i < 3; i++) push(pats[i]);
        checks++; if (ready !== 1'b1) $display("FAIL ovf_ready3 got %b want 1", ready); else passed++;
        push(pats[3]);
        checks++; if (ready !== 1'b0) $display("FAIL ovf_ready4 got %b want 0", ready); else passed++;
        push(32'hFFFF_FFFF);
        checks++; if (mismatch !== 1'b1) $display("FAIL ovf_pulse got %b want 1", mismatch); else passed++;
        checks++; if (fail_count !== 16'd1) $display("FAIL ovf_fails got %0d want 1", fail_count); else passed++;
        for (int i = 0; i < 4; i++) begin
            send_present(|pats[i]);
            send_count(pcs[i]);
            send_stream(pats[i], 8, 1'b1);
            tick();
        end
        checks++; if (words_checked !== 16'd4) $display("FAIL ovf_words got %0d want 4", words_checked); else passed++;
        checks++; if (fail_count !== 16'd1) $display("FAIL ovf_fails_end got %0d want 1", fail_count); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL ovf_ready_end got %b want 1", ready); else passed++;
    endtask

    task automatic test_framing();
        do_reset();
        push(32'h1234_5678);
        send_stream(32'h1234_5678, 6, 1'b1);
        checks++; if (mismatch !== 1'b1) $display("FAIL frame_pulse got %b want 1", mismatch); else passed++;
        checks++; if (fail_count !== 16'd1) $display("FAIL frame_fails got %0d want 1", fail_count); else passed++;
        tick();
        send_present(1'b1);
        send_count(4'd13);
        send_stream(32'h1234_5678, 8, 1'b1);
        tick();
        checks++; if (words_checked !== 16'd1) $display("FAIL frame_words got %0d want 1", words_checked); else passed++;
        checks++; if (fail_count !== 16'd1) $display("FAIL frame_fails2 got %0d want 1", fail_count); else passed++;
        push(32'hA5A5_0F0F);
        send_stream(32'hA5A5_0F0F, 3, 1'b0);
        send_stream(32'hA5A5_0F0F, 8, 1'b1);
        tick();
        checks++; if (words_checked !== 16'd2) $display("FAIL restart_words got %0d want 2", words_checked); else passed++;
        checks++; if (fail_count !== 16'd2) $display("FAIL restart_fails got %0d want 2", fail_count); else passed++;
    endtask

    task automatic test_underflow_reset();
        int base;
        do_reset();
        send_count(4'd0);
        checks++; if (mismatch !== 1'b1) $display("FAIL unf_pulse got %b want 1", mismatch); else passed++;
        checks++; if (fail_count !== 16'd1) $display("FAIL unf_fails got %0d want 1", fail_count); else passed++;
        send_present(1'b0);
        checks++; if (fail_count !== 16'd2) $display("FAIL unf_fails2 got %0d want 2", fail_count); else passed++;
        push(32'h55);
        send_stream(32'h55, 4, 1'b0);
        do_reset();
        checks++; if (wrong !== 1'b0) $display("FAIL rst_wrong got %b want 0", wrong); else passed++;
        checks++; if (fail_count !== 16'd0) $display("FAIL rst_fails got %0d want 0", fail_count); else passed++;
        checks++; if (words_checked !== 16'd0) $display("FAIL rst_words got %0d want 0", words_checked); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL rst_ready got %b want 1", ready); else passed++;
        base = mm_total;
        push(32'h8000_0011);
        send_present(1'b1);
        send_count(4'd3);
        send_stream(32'h8000_0011, 8, 1'b1);
        tick();
        checks++; if (words_checked !== 16'd1) $display("FAIL post_rst_words got %0d want 1", words_checked); else passed++;
        checks++; if (fail_count !== 16'd0) $display("FAIL post_rst_fails got %0d want 0", fail_count); else passed++;
        checks++; if (mm_total - base !== 0) $display("FAIL post_rst_pulses got %0d want 0", mm_total - base); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_correct_errors();
        test_wrong_count();
        test_overflow();
        test_framing();
        test_underflow_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
